// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the retired-instruction trace recorder:
//   - MIPS opcode constants (instr[31:26]) and SPECIAL funct constants (instr[5:0])
//   - 3-bit instruction class codes reported by the classifier and the buffer
//   - 2-bit recorder state codes exported on the 'state' port
// ---------------------------------------------------------------------------
package trace_pkg;

  // Opcode field values
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // Funct field values, meaningful only when opcode is SPECIAL
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  // Instruction classes; also the index of the per-class retire counters
  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_ORI   = 3'd1,
    CLS_LUI   = 3'd2,
    CLS_LW    = 3'd3,
    CLS_SW    = 3'd4,
    CLS_BEQ   = 3'd5,
    CLS_JUMP  = 3'd6,
    CLS_OTHER = 3'd7
  } class_e;

  // Recorder states
  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

endpackage

// File: rtl/instr_classifier.sv
// ---------------------------------------------------------------------------
// instr_classifier
// Purely combinational decode of a MIPS instruction word into a trace class.
// Ports:
//   instr_i  [31:0]  instruction word
//   class_o  [2:0]   class code (see trace_pkg::class_e); unlisted -> OTHER
// ---------------------------------------------------------------------------
module instr_classifier
  import trace_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [2:0]  class_o
);

  // The funct field is only consulted for SPECIAL opcodes; every other
  // opcode is classified from instr[31:26] alone.
  always_comb begin
    class_o = CLS_OTHER;
    case (instr_i[31:26])
      OP_SPECIAL: begin
        case (instr_i[5:0])
          FN_ADD, FN_SUB: class_o = CLS_ALU;
          FN_JR:          class_o = CLS_JUMP;
          default:        class_o = CLS_OTHER;
        endcase
      end
      OP_ORI:  class_o = CLS_ORI;
      OP_LUI:  class_o = CLS_LUI;
      OP_LW:   class_o = CLS_LW;
      OP_SW:   class_o = CLS_SW;
      OP_BEQ:  class_o = CLS_BEQ;
      OP_JAL:  class_o = CLS_JUMP;
      default: class_o = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/instr_trace_buffer.sv
// ---------------------------------------------------------------------------
// instr_trace_buffer
// Retired-instruction trace recorder. Classifies every retired instruction,
// keeps per-class retire counters, and records {pc, instr, class} into a
// circular buffer until a PC trigger plus POST_DEPTH further entries freeze
// it. While frozen the buffer is drained through a valid/ready port.
//
// Parameters: DEPTH (power of two, >=2), POST_DEPTH (0..DEPTH-1), CNT_W.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   retire_valid/pc/instr      retire interface from the core
//   trig_en, trig_pc           PC-match trigger
//   rearm                      FROZEN -> ARMED, flushes the buffer
//   rd_valid/ready/pc/instr/class  drain port (FROZEN only)
//   state                      0 ARMED, 1 POST, 2 FROZEN
//   overflow                   sticky, entry overwritten while ARMED
//   cnt_sel, cnt_out           class counter select / value
//   drop_cnt                   saturating count of retires dropped in FROZEN
//
// Optional macro TRACE_DISPLAY_EN: prints a disassembly line for each
// recorded entry and "TRACE FROZEN" when recording stops (simulation only).
// ---------------------------------------------------------------------------
module instr_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int POST_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             retire_valid,
  input  logic [31:0]      retire_pc,
  input  logic [31:0]      retire_instr,
  input  logic             trig_en,
  input  logic [31:0]      trig_pc,
  input  logic             rearm,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_pc,
  output logic [31:0]      rd_instr,
  output logic [2:0]       rd_class,
  output logic [1:0]       state,
  output logic             overflow,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] POST_INIT = PTR_W'(POST_DEPTH);
  localparam logic [CNT_W-1:0] CTR_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] post_left_q, post_left_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] cls_cnt_q [8];
  logic [CNT_W-1:0] cls_cnt_d [8];

  logic [31:0] mem_pc    [DEPTH];
  logic [31:0] mem_instr [DEPTH];
  logic [2:0]  mem_cls   [DEPTH];

  logic [2:0] retire_cls;
  logic       do_rec;
  logic       do_trig;
  logic       do_pop;

  instr_classifier u_classifier (
    .instr_i (retire_instr),
    .class_o (retire_cls)
  );

  assign do_rec  = retire_valid && (state_q == ST_ARMED || state_q == ST_POST);
  assign do_trig = retire_valid && trig_en && (retire_pc == trig_pc)
                   && (state_q == ST_ARMED);
  assign rd_valid = (state_q == ST_FROZEN) && (count_q != '0);
  assign do_pop   = rd_valid && rd_ready;

  // Next-state logic. Recording (ARMED/POST) and popping (FROZEN) never
  // happen in the same state, so the pointer updates cannot collide. A full
  // buffer keeps recording by dropping its oldest entry.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    post_left_d = post_left_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    for (int i = 0; i < 8; i++) begin
      cls_cnt_d[i] = cls_cnt_q[i];
    end

    if (retire_valid) begin
      cls_cnt_d[retire_cls] = cls_cnt_q[retire_cls] + CTR_ONE;
    end

    if (do_rec) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (count_q == CNT_FULL) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (state_q == ST_ARMED) begin
          overflow_d = 1'b1;
        end
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end

    case (state_q)
      ST_ARMED: begin
        if (do_trig) begin
          if (POST_DEPTH == 0) begin
            state_d = ST_FROZEN;
          end else begin
            state_d     = ST_POST;
            post_left_d = POST_INIT;
          end
        end
      end
      ST_POST: begin
        if (do_rec) begin
          post_left_d = post_left_q - PTR_ONE;
          if (post_left_q == PTR_ONE) begin
            state_d = ST_FROZEN;
          end
        end
      end
      ST_FROZEN: begin
        if (retire_valid && (drop_q != {CNT_W{1'b1}})) begin
          drop_d = drop_q + CTR_ONE;
        end
        if (do_pop) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          count_d  = count_q - CNT_ONE;
        end
        // The flush overrides any pop or drop taken in the same cycle.
        if (rearm) begin
          state_d    = ST_ARMED;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          drop_d     = '0;
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // Control and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARMED;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_left_q <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
      for (int i = 0; i < 8; i++) begin
        cls_cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      post_left_q <= post_left_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      for (int i = 0; i < 8; i++) begin
        cls_cnt_q[i] <= cls_cnt_d[i];
      end
    end
  end

  // Entry storage needs no reset: stale contents are unreachable because
  // count is cleared and the read port is gated by rd_valid.
  always_ff @(posedge clk) begin
    if (do_rec) begin
      mem_pc[wr_ptr_q]    <= retire_pc;
      mem_instr[wr_ptr_q] <= retire_instr;
      mem_cls[wr_ptr_q]   <= retire_cls;
    end
  end

  assign rd_pc    = rd_valid ? mem_pc[rd_ptr_q]    : '0;
  assign rd_instr = rd_valid ? mem_instr[rd_ptr_q] : '0;
  assign rd_class = rd_valid ? mem_cls[rd_ptr_q]   : '0;

  assign state    = state_q;
  assign overflow = overflow_q;
  assign cnt_out  = cls_cnt_q[cnt_sel];
  assign drop_cnt = drop_q;

`ifdef TRACE_DISPLAY_EN
  logic [4:0]  dis_rs, dis_rt, dis_rd;
  logic [15:0] dis_imm;
  logic [31:0] dis_beq_tgt, dis_jal_tgt;

  assign dis_rs      = retire_instr[25:21];
  assign dis_rt      = retire_instr[20:16];
  assign dis_rd      = retire_instr[15:11];
  assign dis_imm     = retire_instr[15:0];
  assign dis_beq_tgt = retire_pc + 32'd4 + {{14{dis_imm[15]}}, dis_imm, 2'b00};
  assign dis_jal_tgt = {retire_pc[31:28], retire_instr[25:0], 2'b00};

  // Disassembly trace of every recorded entry, reusing the classifier result.
  always_ff @(posedge clk) begin
    if (rst_n && do_rec) begin
      case (retire_cls)
        CLS_ALU:  $display("@%08h: %s $%0d, $%0d, $%0d", retire_pc,
                           (retire_instr[5:0] == FN_SUB) ? "sub" : "add",
                           dis_rd, dis_rs, dis_rt);
        CLS_ORI:  $display("@%08h: ori $%0d, $%0d, 0x%04h", retire_pc,
                           dis_rt, dis_rs, dis_imm);
        CLS_LUI:  $display("@%08h: lui $%0d, 0x%04h", retire_pc, dis_rt, dis_imm);
        CLS_LW:   $display("@%08h: lw $%0d, 0x%04h($%0d)", retire_pc,
                           dis_rt, dis_imm, dis_rs);
        CLS_SW:   $display("@%08h: sw $%0d, 0x%04h($%0d)", retire_pc,
                           dis_rt, dis_imm, dis_rs);
        CLS_BEQ:  $display("@%08h: beq $%0d, $%0d, 0x%04h -> %08h", retire_pc,
                           dis_rs, dis_rt, dis_imm, dis_beq_tgt);
        CLS_JUMP: begin
          if (retire_instr[31:26] == OP_JAL) begin
            $display("@%08h: jal 0x%07h -> %08h", retire_pc,
                     retire_instr[25:0], dis_jal_tgt);
          end else begin
            $display("@%08h: jr $%0d", retire_pc, dis_rs);
          end
        end
        default:  $display("@%08h: unknown 0x%08h", retire_pc, retire_instr);
      endcase
    end
    if (rst_n && (state_q != ST_FROZEN) && (state_d == ST_FROZEN)) begin
      $display("TRACE FROZEN");
    end
  end
`endif

endmodule

// File: tb/tb_instr_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_instr_trace_buffer
// Directed bench for instr_trace_buffer. Two instances share all inputs:
// u_dut4 uses POST_DEPTH=4 and u_dut0 uses POST_DEPTH=0, so each scenario
// can look at whichever trigger behaviour it needs.
// ---------------------------------------------------------------------------
module tb_instr_trace_buffer;

  localparam logic [31:0] I_ORI  = 32'h3401_1234;  // ori $1,$0,0x1234
  localparam logic [31:0] I_LUI  = 32'h3C02_8000;  // lui $2,0x8000
  localparam logic [31:0] I_ADD  = 32'h0022_1820;  // add $3,$1,$2
  localparam logic [31:0] I_LW   = 32'h8C04_0004;  // lw  $4,4($0)
  localparam logic [31:0] I_SW   = 32'hAC04_0008;  // sw  $4,8($0)
  localparam logic [31:0] I_SUB  = 32'h0022_2822;  // sub $5,$1,$2
  localparam logic [31:0] I_SLL  = 32'h0000_0000;  // sll (unlisted funct)
  localparam logic [31:0] I_ADDI = 32'h2000_0000;  // addi (unlisted opcode)
  localparam logic [31:0] I_BEQ  = 32'h1022_FFFF;  // beq $1,$2,-1
  localparam logic [31:0] I_JAL  = 32'h0C00_0100;  // jal 0x100
  localparam logic [31:0] I_JR   = 32'h03E0_0008;  // jr  $31

  logic        clk = 1'b0;
  logic        rst_n;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_instr;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        rearm;
  logic        rd_ready;
  logic [2:0]  cnt_sel;

  logic        d4_rd_valid, d0_rd_valid;
  logic [31:0] d4_rd_pc, d0_rd_pc, d4_rd_instr, d0_rd_instr;
  logic [2:0]  d4_rd_class, d0_rd_class;
  logic [1:0]  d4_state, d0_state;
  logic        d4_overflow, d0_overflow;
  logic [31:0] d4_cnt_out, d0_cnt_out, d4_drop_cnt, d0_drop_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  instr_trace_buffer #(.DEPTH(16), .POST_DEPTH(4), .CNT_W(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .trig_en(trig_en), .trig_pc(trig_pc), .rearm(rearm),
    .rd_valid(d4_rd_valid), .rd_ready(rd_ready), .rd_pc(d4_rd_pc), .rd_instr(d4_rd_instr),
    .rd_class(d4_rd_class), .state(d4_state), .overflow(d4_overflow), .cnt_sel(cnt_sel),
    .cnt_out(d4_cnt_out), .drop_cnt(d4_drop_cnt)
  );

  instr_trace_buffer #(.DEPTH(16), .POST_DEPTH(0), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .trig_en(trig_en), .trig_pc(trig_pc), .rearm(rearm),
    .rd_valid(d0_rd_valid), .rd_ready(rd_ready), .rd_pc(d0_rd_pc), .rd_instr(d0_rd_instr),
    .rd_class(d0_rd_class), .state(d0_state), .overflow(d0_overflow), .cnt_sel(cnt_sel),
    .cnt_out(d0_cnt_out), .drop_cnt(d0_drop_cnt)
  );

  // Reset both instances; every task starts and ends on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0; retire_valid = 1'b0; retire_pc = '0; retire_instr = '0;
    trig_en = 1'b0; trig_pc = '0; rearm = 1'b0; rd_ready = 1'b0; cnt_sel = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One retire, sampled at the next rising edge.
  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    retire_valid = 1'b1; retire_pc = pc; retire_instr = instr;
    @(negedge clk);
    retire_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (d4_state !== 2'd0) $display("[TB] FAIL reset_state: got %0d expected 0", d4_state); else pass_cnt++;
    total_cnt++; if (d4_rd_valid !== 1'b0) $display("[TB] FAIL reset_rd_valid: got %0b expected 0", d4_rd_valid); else pass_cnt++;
    total_cnt++; if ({d4_rd_pc, d4_rd_instr, d4_rd_class} !== '0) $display("[TB] FAIL reset_rd_data: got %h/%h/%0d expected 0", d4_rd_pc, d4_rd_instr, d4_rd_class); else pass_cnt++;
    total_cnt++; if ({d4_overflow, d4_drop_cnt} !== '0) $display("[TB] FAIL reset_ovf_drop: got %0b/%0d expected 0/0", d4_overflow, d4_drop_cnt); else pass_cnt++;
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s); #1;
      total_cnt++; if (d4_cnt_out !== 32'd0) $display("[TB] FAIL reset_cnt[%0d]: got %0d expected 0", s, d4_cnt_out); else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_classify();
    logic [31:0] exp_cnt [8];
    exp_cnt = '{32'd2, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2};
    do_reset();
    retire(32'h3000, I_ORI);
    retire(32'h3004, I_LUI);
    retire(32'h3008, I_ADD);
    retire(32'h300C, I_LW);
    retire(32'h3010, I_SW);
    total_cnt++; if (d4_state !== 2'd0) $display("[TB] FAIL classify_state: got %0d expected 0", d4_state); else pass_cnt++;
    total_cnt++; if (d4_rd_valid !== 1'b0) $display("[TB] FAIL classify_rd_valid: got %0b expected 0", d4_rd_valid); else pass_cnt++;
    retire(32'h3014, I_SUB);
    retire(32'h3018, I_SLL);
    retire(32'h301C, I_ADDI);
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s); #1;
      total_cnt++; if (d4_cnt_out !== exp_cnt[s]) $display("[TB] FAIL classify_cnt[%0d]: got %0d expected %0d", s, d4_cnt_out, exp_cnt[s]); else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_trigger_post();
    logic [1:0] exp_st;
    do_reset();
    trig_en = 1'b1; trig_pc = 32'h3010;
    for (int i = 0; i < 9; i++) begin
      retire(32'h3000 + 32'(4 * i), I_ORI + 32'(i));
      exp_st = (i < 4) ? 2'd0 : (i < 8) ? 2'd1 : 2'd2;
      total_cnt++; if (d4_state !== exp_st) $display("[TB] FAIL post_state[%0d]: got %0d expected %0d", i, d4_state, exp_st); else pass_cnt++;
    end
    total_cnt++; if (d0_state !== 2'd2) $display("[TB] FAIL post0_state: got %0d expected 2", d0_state); else pass_cnt++;
    total_cnt++; if (d0_drop_cnt !== 32'd4) $display("[TB] FAIL post0_drop: got %0d expected 4", d0_drop_cnt); else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      total_cnt++;
      if (d4_rd_valid !== 1'b1 || d4_rd_pc !== 32'h3000 + 32'(4 * i) || d4_rd_class !== 3'd1
          || d4_rd_instr !== I_ORI + 32'(i))
        $display("[TB] FAIL post_drain[%0d]: got v=%0b pc=%h cls=%0d ins=%h expected v=1 pc=%h cls=1 ins=%h",
                 i, d4_rd_valid, d4_rd_pc, d4_rd_class, d4_rd_instr, 32'h3000 + 32'(4 * i), I_ORI + 32'(i));
      else pass_cnt++;
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    total_cnt++; if (d4_rd_valid !== 1'b0 || d4_rd_pc !== 32'd0) $display("[TB] FAIL post_empty: got v=%0b pc=%h expected 0/0", d4_rd_valid, d4_rd_pc); else pass_cnt++;
  endtask

  // Overflow, FROZEN drops, rearm with a simultaneous pop, and rearm ignored
  // in POST all continue from the same buffer contents.
  task automatic test_overflow_rearm();
    do_reset();
    trig_en = 1'b1; trig_pc = 32'h3050;
    for (int i = 0; i < 21; i++) retire(32'h3000 + 32'(4 * i), I_ORI);
    total_cnt++; if (d0_state !== 2'd2 || d0_overflow !== 1'b1) $display("[TB] FAIL ovf_flag: got st=%0d ovf=%0b expected 2/1", d0_state, d0_overflow); else pass_cnt++;
    retire(32'h4000, I_BEQ);
    retire(32'h4004, I_JAL);
    retire(32'h4008, I_JR);
    total_cnt++; if (d0_drop_cnt !== 32'd3) $display("[TB] FAIL frozen_drop: got %0d expected 3", d0_drop_cnt); else pass_cnt++;
    cnt_sel = 3'd5; #1;
    total_cnt++; if (d0_cnt_out !== 32'd1) $display("[TB] FAIL frozen_beq_cnt: got %0d expected 1", d0_cnt_out); else pass_cnt++;
    cnt_sel = 3'd6; #1;
    total_cnt++; if (d0_cnt_out !== 32'd2) $display("[TB] FAIL frozen_jump_cnt: got %0d expected 2", d0_cnt_out); else pass_cnt++;
    @(negedge clk);
    for (int k = 0; k < 15; k++) begin
      total_cnt++;
      if (d0_rd_valid !== 1'b1 || d0_rd_pc !== 32'h3014 + 32'(4 * k))
        $display("[TB] FAIL ovf_drain[%0d]: got v=%0b pc=%h expected v=1 pc=%h", k, d0_rd_valid, d0_rd_pc, 32'h3014 + 32'(4 * k));
      else pass_cnt++;
      rd_ready = 1'b1;
      @(negedge clk);
    end
    total_cnt++; if (d0_rd_valid !== 1'b1 || d0_rd_pc !== 32'h3050) $display("[TB] FAIL ovf_newest: got v=%0b pc=%h expected v=1 pc=00003050", d0_rd_valid, d0_rd_pc); else pass_cnt++;
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0; rd_ready = 1'b0;
    total_cnt++; if (d0_state !== 2'd0 || d0_overflow !== 1'b0 || d0_drop_cnt !== 32'd0 || d0_rd_valid !== 1'b0)
      $display("[TB] FAIL rearm_clear: got st=%0d ovf=%0b drop=%0d v=%0b expected 0/0/0/0", d0_state, d0_overflow, d0_drop_cnt, d0_rd_valid);
    else pass_cnt++;
    total_cnt++; if (d4_state !== 2'd1) $display("[TB] FAIL rearm_ignored_post: got %0d expected 1", d4_state); else pass_cnt++;
    cnt_sel = 3'd1; #1;
    total_cnt++; if (d0_cnt_out !== 32'd21) $display("[TB] FAIL rearm_keep_cnt: got %0d expected 21", d0_cnt_out); else pass_cnt++;
    @(negedge clk);
    retire(32'h3050, I_SUB);
    total_cnt++; if (d0_rd_valid !== 1'b1 || d0_rd_pc !== 32'h3050 || d0_rd_instr !== I_SUB || d0_rd_class !== 3'd0)
      $display("[TB] FAIL rearm_fresh: got v=%0b pc=%h ins=%h cls=%0d expected 1/00003050/%h/0", d0_rd_valid, d0_rd_pc, d0_rd_instr, d0_rd_class, I_SUB);
    else pass_cnt++;
    total_cnt++; if (d4_state !== 2'd2) $display("[TB] FAIL post_last_freeze: got %0d expected 2", d4_state); else pass_cnt++;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    total_cnt++; if (d0_rd_valid !== 1'b0) $display("[TB] FAIL rearm_single_pop: got %0b expected 0", d0_rd_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_post();
    do_reset();
    trig_en = 1'b1; trig_pc = 32'h3000;
    retire(32'h3000, I_LW);
    retire(32'h3004, I_SW);
    total_cnt++; if (d4_state !== 2'd1 || d0_rd_valid !== 1'b1) $display("[TB] FAIL pre_reset: got st=%0d v0=%0b expected 1/1", d4_state, d0_rd_valid); else pass_cnt++;
    cnt_sel = 3'd3;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (d4_state !== 2'd0 || d0_state !== 2'd0) $display("[TB] FAIL async_reset_state: got %0d/%0d expected 0/0", d4_state, d0_state); else pass_cnt++;
    total_cnt++; if (d0_rd_valid !== 1'b0 || d0_rd_pc !== 32'd0 || d0_rd_instr !== 32'd0)
      $display("[TB] FAIL async_reset_rd: got v=%0b pc=%h ins=%h expected 0", d0_rd_valid, d0_rd_pc, d0_rd_instr);
    else pass_cnt++;
    total_cnt++; if (d0_drop_cnt !== 32'd0 || d4_cnt_out !== 32'd0) $display("[TB] FAIL async_reset_cnt: got drop=%0d lw=%0d expected 0/0", d0_drop_cnt, d4_cnt_out); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_classify();
    test_trigger_post();
    test_overflow_rearm();
    test_reset_mid_post();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
